// File: rtl/ldpc_shift_scheduler.sv
// Walks the QC-LDPC base-matrix shift table layer by layer and issues one shifter command per active circulant, per iteration.
// All outputs registered; an active entry stalls the walk while sh_ready is low.
module ldpc_shift_scheduler #(
  parameter int Z        = 52,
  parameter int ROWS     = 4,
  parameter int COLS     = 8,
  parameter int MAX_ITER = 8,
  parameter int SW       = $clog2(Z),
  parameter int AW       = $clog2(ROWS*COLS),
  parameter int IW       = $clog2(MAX_ITER+1),
  parameter int RW       = $clog2(ROWS),
  parameter int CW       = $clog2(COLS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic          cfg_active,
  input  logic [SW-1:0] cfg_shift,
  output logic          cfg_err,
  input  logic          start,
  input  logic [IW-1:0] iter_max,
  input  logic          early_stop,
  input  logic          sh_ready,
  output logic          shift_en,
  output logic [SW-1:0] shift_amount,
  output logic [RW-1:0] row_idx,
  output logic [CW-1:0] col_idx,
  output logic          layer_done,
  output logic          busy,
  output logic          done,
  output logic [IW-1:0] iter_count
);
  localparam int NENT = ROWS * COLS;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_CHK} state_t;
  state_t state, state_nxt;

  logic          tbl_act [NENT];
  logic [SW-1:0] tbl_sh  [NENT];

  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [IW-1:0] limit;
  logic [IW-1:0] iter_inc;
  logic [AW-1:0] rd_idx;
  logic          cur_act;
  logic [SW-1:0] cur_sh;
  logic          last_col, last_row, advance, issue, finish, cfg_ok;

  assign rd_idx   = AW'(int'(row) * COLS + int'(col));
  assign cur_act  = tbl_act[rd_idx];
  assign cur_sh   = tbl_sh[rd_idx];
  assign last_col = (col == CW'(COLS-1));
  assign last_row = (row == RW'(ROWS-1));
  assign iter_inc = iter_count + IW'(1);
  assign finish   = early_stop || (iter_inc == limit);

  // Range checks are widened by one bit so they stay correct when the bound is a power of two.
  assign cfg_ok = cfg_we && (state == S_IDLE) && !start &&
                  ({1'b0, cfg_addr} < (AW+1)'(NENT)) &&
                  ({1'b0, cfg_shift} < (SW+1)'(Z));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    advance   = 1'b0;
    issue     = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_SCAN;
      S_SCAN: begin
        advance = !cur_act || sh_ready;
        issue   = cur_act && sh_ready;
        if (advance && last_col && last_row) state_nxt = S_CHK;
      end
      S_CHK:   state_nxt = finish ? S_IDLE : S_SCAN;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NENT; i++) begin
        tbl_act[i] <= 1'b0;
        tbl_sh[i]  <= '0;
      end
    end else if (cfg_ok) begin
      tbl_act[cfg_addr] <= cfg_active;
      tbl_sh[cfg_addr]  <= cfg_shift;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row          <= '0;
      col          <= '0;
      limit        <= '0;
      iter_count   <= '0;
      shift_en     <= 1'b0;
      shift_amount <= '0;
      row_idx      <= '0;
      col_idx      <= '0;
      layer_done   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      cfg_err    <= cfg_we && !cfg_ok;
      shift_en   <= issue;
      layer_done <= advance && last_col;
      done       <= (state == S_CHK) && finish;
      if (issue) begin
        shift_amount <= cur_sh;
        row_idx      <= row;
        col_idx      <= col;
      end
      case (state)
        S_IDLE: if (start) begin
          limit      <= (iter_max == '0) ? IW'(1) : iter_max;
          row        <= '0;
          col        <= '0;
          iter_count <= '0;
          busy       <= 1'b1;
        end
        S_SCAN: if (advance) begin
          col <= last_col ? '0 : col + CW'(1);
          if (last_col && !last_row) row <= row + RW'(1);
        end
        S_CHK: begin
          iter_count <= iter_inc;
          if (finish) busy <= 1'b0;
          else        row  <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ldpc_shift_scheduler.sv
// Randomized bench: a timeline model of the table walk predicts every output per cycle; directed runs pin literal event times.
module tb_ldpc_shift_scheduler;
  localparam int Z = 52, ROWS = 4, COLS = 8, MAX_ITER = 8;
  localparam int SW = 6, AW = 5, IW = 4, RW = 2, CW = 3;
  localparam int NENT = ROWS * COLS;
  localparam int MAXT = 4096;

  logic          clk, rst;
  logic          cfg_we, cfg_active, cfg_err;
  logic [AW-1:0] cfg_addr;
  logic [SW-1:0] cfg_shift, shift_amount;
  logic          start, early_stop, sh_ready;
  logic [IW-1:0] iter_max, iter_count;
  logic          shift_en, layer_done, busy, done;
  logic [RW-1:0] row_idx;
  logic [CW-1:0] col_idx;

  ldpc_shift_scheduler #(.Z(Z), .ROWS(ROWS), .COLS(COLS), .MAX_ITER(MAX_ITER)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_active(cfg_active),
    .cfg_shift(cfg_shift), .cfg_err(cfg_err), .start(start), .iter_max(iter_max),
    .early_stop(early_stop), .sh_ready(sh_ready), .shift_en(shift_en),
    .shift_amount(shift_amount), .row_idx(row_idx), .col_idx(col_idx),
    .layer_done(layer_done), .busy(busy), .done(done), .iter_count(iter_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int run_t = 0;
  bit chk_en = 1'b0;

  // model table and per-run stimulus / expectation timelines
  bit mact [NENT];
  int msh  [NENT];
  bit rdy [MAXT], es [MAXT], stx [MAXT], cwe [MAXT];
  int exp_se [MAXT], exp_amt [MAXT], exp_row [MAXT], exp_col [MAXT];
  int exp_ld [MAXT], exp_busy [MAXT], exp_done [MAXT], exp_err [MAXT], exp_ic [MAXT];
  int done_t, prev_ic = 0;
  int se_q[$], ld_q[$], done_q[$];

  task automatic chk(input string nm, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s t=%0d got=%0d want=%0d", nm, run_t, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("shift_en", int'(shift_en), exp_se[run_t]);
      chk("layer_done", int'(layer_done), exp_ld[run_t]);
      chk("busy", int'(busy), exp_busy[run_t]);
      chk("done", int'(done), exp_done[run_t]);
      chk("iter_count", int'(iter_count), exp_ic[run_t]);
      chk("cfg_err", int'(cfg_err), exp_err[run_t]);
      if (exp_se[run_t] != 0) begin
        chk("shift_amount", int'(shift_amount), exp_amt[run_t]);
        chk("row_idx", int'(row_idx), exp_row[run_t]);
        chk("col_idx", int'(col_idx), exp_col[run_t]);
      end
      if (shift_en) se_q.push_back(run_t);
      if (layer_done) ld_q.push_back(run_t);
      if (done) done_q.push_back(run_t);
    end
  end

  // Timeline: each entry takes one cycle once the datapath is ready; each iteration adds one check cycle.
  task automatic build_model(input int lim);
    int t, cnt, l;
    bit fin;
    l = (lim == 0) ? 1 : lim;
    for (int i = 0; i < MAXT; i++) begin
      exp_se[i] = 0; exp_amt[i] = 0; exp_row[i] = 0; exp_col[i] = 0; exp_ld[i] = 0;
      exp_busy[i] = 0; exp_done[i] = 0; exp_err[i] = 0; exp_ic[i] = (i == 0) ? prev_ic : 0;
    end
    t = 1; cnt = 0; fin = 1'b0;
    while (!fin) begin
      for (int e = 0; e < NENT; e++) begin
        if (mact[e]) begin
          while (!rdy[t]) t++;
          exp_se[t+1] = 1; exp_amt[t+1] = msh[e];
          exp_row[t+1] = e / COLS; exp_col[t+1] = e % COLS;
        end
        if (e % COLS == COLS - 1) exp_ld[t+1] = 1;
        t++;
      end
      cnt++;
      for (int i = t + 1; i < MAXT; i++) exp_ic[i] = cnt;
      if (es[t] || cnt == l) fin = 1'b1;
      else t++;
    end
    done_t = t + 1;
    exp_done[done_t] = 1;
    for (int i = 1; i < done_t; i++) exp_busy[i] = 1;
    prev_ic = cnt;
  endtask

  task automatic fill(input int rmode, input int emode);
    for (int i = 0; i < MAXT; i++) begin
      case (rmode)
        0: rdy[i] = ($urandom_range(0, 1) == 1);
        1: rdy[i] = ($urandom_range(0, 3) != 0);
        default: rdy[i] = 1'b1;
      endcase
      if (i >= 2000) rdy[i] = 1'b1;
      case (emode)
        1: es[i] = ($urandom_range(0, 7) == 0);
        2: es[i] = ($urandom_range(0, 1) == 1);
        default: es[i] = 1'b0;
      endcase
    end
  endtask

  task automatic idle_inputs();
    start = 1'b0; cfg_we = 1'b0; sh_ready = 1'b0; early_stop = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_shift_en"}, int'(shift_en), 0);
    chk({tag, "_amount"}, int'(shift_amount), 0);
    chk({tag, "_row"}, int'(row_idx), 0);
    chk({tag, "_col"}, int'(col_idx), 0);
    chk({tag, "_layer_done"}, int'(layer_done), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_iter_count"}, int'(iter_count), 0);
    chk({tag, "_cfg_err"}, int'(cfg_err), 0);
  endtask

  task automatic cfg_write(input int a, input bit act, input int sh);
    bit rej;
    @(posedge clk); #1;
    chk_en = 1'b0;
    start = 1'b0; cfg_we = 1'b1; cfg_addr = AW'(a); cfg_active = act; cfg_shift = SW'(sh);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    @(negedge clk);
    rej = (sh >= Z);
    chk("cfg_write_err", int'(cfg_err), int'(rej));
    if (!rej) begin mact[a] = act; msh[a] = sh; end
  endtask

  task automatic run(input int lim, input int abort_at);
    build_model(lim);
    se_q.delete(); ld_q.delete(); done_q.delete();
    if (done_t > MAXT - 8) begin
      bad++;
      $display("FAIL model_horizon done_t=%0d limit=%0d", done_t, MAXT - 8);
      $fatal(1, "model horizon exceeded");
    end
    for (int t = 0; t < MAXT; t++) begin stx[t] = 1'b0; cwe[t] = 1'b0; end
    for (int t = 1; t < done_t; t++) stx[t] = ($urandom_range(0, 15) == 0);
    stx[5] = 1'b1;
    for (int t = 0; t < done_t; t++) begin
      cwe[t] = ($urandom_range(0, 7) == 0);
      if (cwe[t]) exp_err[t+1] = 1;
    end
    for (int t = 0; t <= done_t + 2; t++) begin
      @(posedge clk); #1;
      if (t == abort_at) begin
        chk_en = 1'b0;
        rst = 1'b1;
        #1;
        chk_zero("abort");
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int e = 0; e < NENT; e++) begin mact[e] = 1'b0; msh[e] = 0; end
        prev_ic = 0;
        return;
      end
      run_t = t; chk_en = 1'b1;
      start = (t == 0) || stx[t];
      iter_max = (t == 0) ? IW'(lim) : IW'($urandom_range(0, 8));
      sh_ready = rdy[t]; early_stop = es[t]; cfg_we = cwe[t];
      cfg_addr = AW'($urandom); cfg_shift = SW'($urandom); cfg_active = 1'($urandom);
    end
    @(posedge clk); #1;
    chk_en = 1'b0;
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1; idle_inputs();
    cfg_addr = '0; cfg_active = 1'b0; cfg_shift = '0; iter_max = '0;
    for (int e = 0; e < NENT; e++) begin mact[e] = 1'b0; msh[e] = 0; end
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;

    // T1 reference scenario
    cfg_write(0, 1'b1, 5); cfg_write(3, 1'b1, 51); cfg_write(31, 1'b1, 0);
    fill(2, 0);
    run(1, -1);
    chk("t1_nshift", se_q.size(), 3);
    chk("t1_shift0", se_q[0], 2); chk("t1_shift1", se_q[1], 5); chk("t1_shift2", se_q[2], 33);
    chk("t1_nlayer", ld_q.size(), 4);
    chk("t1_layer0", ld_q[0], 9); chk("t1_layer3", ld_q[3], 33);
    chk("t1_done", done_q[0], 34);
    chk("t1_iter_count", int'(iter_count), 1);

    // T4 out-of-range shift rejected; entry 0 must still issue amount 5 afterwards
    cfg_write(0, 1'b1, 52);

    // T2 datapath stall for cycles 1..3
    fill(2, 0);
    rdy[1] = 1'b0; rdy[2] = 1'b0; rdy[3] = 1'b0;
    run(1, -1);
    chk("t2_shift0", se_q[0], 5); chk("t2_shift1", se_q[1], 8); chk("t2_shift2", se_q[2], 36);
    chk("t2_done", done_q[0], 37);

    // T3 early stop at the first check cycle
    fill(2, 0);
    es[33] = 1'b1;
    run(8, -1);
    chk("t3_ndone", done_q.size(), 1);
    chk("t3_done", done_q[0], 34);
    chk("t3_iter_count", int'(iter_count), 1);

    // T6 iter_max=0 behaves as 1, start pulses while busy ignored
    fill(2, 0);
    run(0, -1);
    chk("t6_ndone", done_q.size(), 1);
    chk("t6_done", done_q[0], 34);

    // T5 reset mid-scan, then a null-table two-iteration run
    fill(2, 0);
    run(1, 10);
    fill(2, 0);
    run(2, -1);
    chk("t5_nshift", se_q.size(), 0);
    chk("t5_done", done_q[0], 67);
    chk("t5_iter_count", int'(iter_count), 2);

    // randomized tables, ready patterns, early stops and limits
    for (int r = 0; r < 10; r++) begin
      int nw;
      nw = $urandom_range(4, 16);
      for (int k = 0; k < nw; k++)
        cfg_write($urandom_range(0, NENT - 1), 1'($urandom_range(0, 1)), $urandom_range(0, 63));
      fill($urandom_range(0, 2), $urandom_range(0, 2));
      run($urandom_range(0, MAX_ITER), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
